// File: rtl/simple_circuit_test_pkg.sv
// Shared definitions for the simple_circuit self-test sequencer.
//  - state_e   : sequencer FSM states
//  - golden()  : fault-free response {E,F,G,H} of the simple_circuit netlist
//  - misr_next(): one MISR update step (poly x^8+x^6+x^5+x^4+1)
//  - MISR_POLY / MISR_SEED constants
package simple_circuit_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SAMPLE  = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Feedback taps for x^6, x^5, x^4 and 1 (x^8 is the shifted-out bit).
    localparam logic [7:0] MISR_POLY = 8'h71;
    localparam logic [7:0] MISR_SEED = 8'hFF;

    // Reference netlist: E=A&B, F=A|C, G=~C, H=A&B&C with vec = {A,B,C}.
    function automatic logic [3:0] golden(input logic [2:0] vec);
        logic a;
        logic b;
        logic c;
        a = vec[2];
        b = vec[1];
        c = vec[0];
        return {a & b, a | c, ~c, a & b & c};
    endfunction

    // Galois-form shift with the response folded into the low nibble.
    function automatic logic [7:0] misr_next(input logic [7:0] sig, input logic [3:0] data);
        return {sig[6:0], 1'b0} ^ (sig[7] ? MISR_POLY : 8'h00) ^ {4'h0, data};
    endfunction

endpackage

// File: rtl/simple_circuit_misr.sv
// 8-bit multiple-input signature register for the simple_circuit self-test.
// Ports: clk, rst_n (async active-low), seed_i (load MISR_SEED),
//        en_i (absorb data_i), data_i[3:0] response {E,F,G,H}, sig_o[7:0].
// Seed has priority over enable; the signature holds when neither is set.
module simple_circuit_misr
    import simple_circuit_test_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       seed_i,
    input  logic       en_i,
    input  logic [3:0] data_i,
    output logic [7:0] sig_o
);

    logic [7:0] sig_q;
    logic [7:0] sig_d;

    // Next signature: seed, absorb a response, or hold.
    always_comb begin
        sig_d = sig_q;
        if (seed_i) begin
            sig_d = MISR_SEED;
        end else if (en_i) begin
            sig_d = misr_next(sig_q, data_i);
        end else begin
            sig_d = sig_q;
        end
    end

    // Signature register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 8'h00;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/simple_circuit_test_ctrl.sv
// Self-test sequencer for one simple_circuit instance. Sweeps vectors 0..7
// NUM_PASSES times, holds each for SETTLE_CYCLES, samples {E,F,G,H}, compares
// against golden() and records a saturating mismatch count plus the first
// failing vector. Start/done handshake toward the detection harness.
// Ports: clk, rst_n, start_i, abort_i, dut_a/b/c_o (vector to DUT),
//        dut_e/f/g/h_i (DUT response), busy_o, done_o, pass_o, err_cnt_o,
//        fail_valid_o, fail_vec_o, sig_o.
// Optional feature macro: SIG_MISR_EN (adds the response MISR; otherwise
// sig_o is tied to 8'h00).
module simple_circuit_test_ctrl
    import simple_circuit_test_pkg::*;
#(
    parameter int NUM_PASSES    = 1,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic                 dut_a_o,
    output logic                 dut_b_o,
    output logic                 dut_c_o,
    input  logic                 dut_e_i,
    input  logic                 dut_f_i,
    input  logic                 dut_g_i,
    input  logic                 dut_h_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic                 fail_valid_o,
    output logic [2:0]           fail_vec_o,
    output logic [7:0]           sig_o
);

    localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    state_e               state_q, state_d;
    logic [2:0]           vec_q, vec_d;
    logic [SET_W-1:0]     settle_q, settle_d;
    logic [PASS_W-1:0]    pass_cnt_q, pass_cnt_d;
    logic [3:0]           obs_q, obs_d;
    logic                 start_prev_q;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 fail_valid_q, fail_valid_d;
    logic [2:0]           fail_vec_q, fail_vec_d;
    logic                 pass_q, pass_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 start_req_s;
    logic                 mismatch_s;

    // A run needs a fresh rising edge of start_i, so a level held through a
    // run (or through reset) never launches a second one.
    assign start_req_s = start_i & ~start_prev_q;
    assign mismatch_s  = (obs_q != golden(vec_q));

    // Next-state and datapath updates; abort overrides every state.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        settle_d     = settle_q;
        pass_cnt_d   = pass_cnt_q;
        obs_d        = obs_q;
        err_cnt_d    = err_cnt_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        pass_d       = pass_q;
        done_d       = 1'b0;
        if (abort_i) begin
            state_d = ST_IDLE;
            vec_d   = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_req_s) begin
                        state_d      = ST_APPLY;
                        vec_d        = 3'd0;
                        settle_d     = '0;
                        pass_cnt_d   = '0;
                        err_cnt_d    = '0;
                        fail_valid_d = 1'b0;
                        fail_vec_d   = 3'd0;
                        pass_d       = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_APPLY: begin
                    if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    obs_d   = {dut_e_i, dut_f_i, dut_g_i, dut_h_i};
                    state_d = ST_COMPARE;
                end
                ST_COMPARE: begin
                    if (mismatch_s) begin
                        err_cnt_d = (err_cnt_q == ERR_MAX) ? ERR_MAX : err_cnt_q + ERR_CNT_W'(1);
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            fail_vec_d   = vec_q;
                        end else begin
                            fail_valid_d = fail_valid_q;
                        end
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    settle_d = '0;
                    if (vec_q == 3'd7) begin
                        if (pass_cnt_q == PASS_W'(NUM_PASSES - 1)) begin
                            // Last vector stays on the DUT inputs after the run.
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            pass_d  = (err_cnt_d == '0);
                        end else begin
                            state_d    = ST_APPLY;
                            vec_d      = 3'd0;
                            pass_cnt_d = pass_cnt_q + PASS_W'(1);
                        end
                    end else begin
                        state_d = ST_APPLY;
                        vec_d   = vec_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vec_q        <= 3'd0;
            settle_q     <= '0;
            pass_cnt_q   <= '0;
            obs_q        <= 4'h0;
            start_prev_q <= 1'b1;
            err_cnt_q    <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 3'd0;
            pass_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            settle_q     <= settle_d;
            pass_cnt_q   <= pass_cnt_d;
            obs_q        <= obs_d;
            start_prev_q <= start_i;
            err_cnt_q    <= err_cnt_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            pass_q       <= pass_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign dut_a_o      = vec_q[2];
    assign dut_b_o      = vec_q[1];
    assign dut_c_o      = vec_q[0];
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign err_cnt_o    = err_cnt_q;
    assign fail_valid_o = fail_valid_q;
    assign fail_vec_o   = fail_vec_q;

`ifdef SIG_MISR_EN
    logic misr_seed_s;
    logic misr_en_s;

    assign misr_seed_s = (state_q == ST_IDLE) & start_req_s & ~abort_i;
    assign misr_en_s   = (state_q == ST_COMPARE) & ~abort_i;

    simple_circuit_misr u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .seed_i (misr_seed_s),
        .en_i   (misr_en_s),
        .data_i (obs_q),
        .sig_o  (sig_o)
    );
`else
    assign sig_o = 8'h00;
`endif

endmodule

// File: tb/tb_simple_circuit_test_ctrl.sv
module tb_simple_circuit_test_ctrl;

    logic clk;
    logic rst_n;
    logic [2:0] start_s;
    logic abort_s;
    logic [3:0] sa0_s;
    logic [3:0] sa1_s;

    logic [2:0] in_s   [3];
    logic [3:0] obs_s  [3];
    logic [2:0] busy_s, done_s, pass_s, fv_s;
    logic [7:0] err0_s, err1_s;
    logic [2:0] err2_s;
    logic [7:0] err_a  [3];
    logic [2:0] fvec_a [3];
    logic [7:0] sig_a  [3];

    int n_checks = 0;
    int n_errors = 0;

    // Instance parameters: NUM_PASSES, SETTLE_CYCLES, saturation limit.
    int passes_p [3] = '{1, 2, 3};
    int settle_p [3] = '{2, 2, 1};
    int errmax_p [3] = '{255, 255, 7};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truth table of the fault-free netlist, indexed by vector value {A,B,C}.
    function automatic logic [3:0] ref_gold(input logic [2:0] v);
        logic e, f, g, h;
        e = (v >= 3'd6);
        f = (v != 3'd0) && (v != 3'd2);
        g = (v % 3'd2) == 3'd0;
        h = (v == 3'd7);
        return {e, f, g, h};
    endfunction

    // Netlist with stuck-at faults applied on {E,F,G,H}.
    function automatic logic [3:0] circ(input logic [2:0] v, input logic [3:0] s0, input logic [3:0] s1);
        return (ref_gold(v) & ~s0) | s1;
    endfunction

    // Signature as polynomial: sig*x mod P, plus the response.
    function automatic logic [7:0] misr_ref(input logic [7:0] sig, input logic [3:0] d);
        logic [8:0] t;
        t = {sig, 1'b0};
        if (t[8]) t = t ^ 9'h171;
        return t[7:0] ^ {4'h0, d};
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_circ
        assign obs_s[k] = circ(in_s[k], sa0_s, sa1_s);
    end
    assign err_a[0] = err0_s;
    assign err_a[1] = err1_s;
    assign err_a[2] = {5'd0, err2_s};

    simple_circuit_test_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .start_i(start_s[0]), .abort_i(abort_s),
        .dut_a_o(in_s[0][2]), .dut_b_o(in_s[0][1]), .dut_c_o(in_s[0][0]),
        .dut_e_i(obs_s[0][3]), .dut_f_i(obs_s[0][2]), .dut_g_i(obs_s[0][1]), .dut_h_i(obs_s[0][0]),
        .busy_o(busy_s[0]), .done_o(done_s[0]), .pass_o(pass_s[0]), .err_cnt_o(err0_s),
        .fail_valid_o(fv_s[0]), .fail_vec_o(fvec_a[0]), .sig_o(sig_a[0]));

    simple_circuit_test_ctrl #(.NUM_PASSES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start_i(start_s[1]), .abort_i(abort_s),
        .dut_a_o(in_s[1][2]), .dut_b_o(in_s[1][1]), .dut_c_o(in_s[1][0]),
        .dut_e_i(obs_s[1][3]), .dut_f_i(obs_s[1][2]), .dut_g_i(obs_s[1][1]), .dut_h_i(obs_s[1][0]),
        .busy_o(busy_s[1]), .done_o(done_s[1]), .pass_o(pass_s[1]), .err_cnt_o(err1_s),
        .fail_valid_o(fv_s[1]), .fail_vec_o(fvec_a[1]), .sig_o(sig_a[1]));

    simple_circuit_test_ctrl #(.NUM_PASSES(3), .SETTLE_CYCLES(1), .ERR_CNT_W(3)) u2 (
        .clk(clk), .rst_n(rst_n), .start_i(start_s[2]), .abort_i(abort_s),
        .dut_a_o(in_s[2][2]), .dut_b_o(in_s[2][1]), .dut_c_o(in_s[2][0]),
        .dut_e_i(obs_s[2][3]), .dut_f_i(obs_s[2][2]), .dut_g_i(obs_s[2][1]), .dut_h_i(obs_s[2][0]),
        .busy_o(busy_s[2]), .done_o(done_s[2]), .pass_o(pass_s[2]), .err_cnt_o(err2_s),
        .fail_valid_o(fv_s[2]), .fail_vec_o(fvec_a[2]), .sig_o(sig_a[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Whole-run expectation computed straight from the sweep definition.
    task automatic model(input int inst, input logic [3:0] s0, input logic [3:0] s1,
                         output int err, output logic fv, output logic [2:0] fvec,
                         output logic pass, output logic [7:0] sig);
        logic [3:0] o;
        err = 0; fv = 1'b0; fvec = 3'd0; sig = 8'hFF;
        for (int p = 0; p < passes_p[inst]; p++) begin
            for (int v = 0; v < 8; v++) begin
                o = circ(3'(v), s0, s1);
                if (o != ref_gold(3'(v))) begin
                    if (!fv) begin fv = 1'b1; fvec = 3'(v); end
                    err++;
                end
                sig = misr_ref(sig, o);
            end
        end
        if (err > errmax_p[inst]) err = errmax_p[inst];
        pass = (err == 0);
`ifndef SIG_MISR_EN
        sig = 8'h00;
`endif
    endtask

    // Launch one run with a start pulse and collect results at done_o.
    task automatic do_run(input int inst, input logic [3:0] s0, input logic [3:0] s1,
                          output int lat, output logic [7:0] err, output logic fv,
                          output logic [2:0] fvec, output logic pass, output logic [7:0] sig);
        sa0_s = s0; sa1_s = s1;
        start_s[inst] = 1'b1;
        @(negedge clk);
        start_s[inst] = 1'b0;
        lat = 1;
        check("busy_after_start", 32'(busy_s[inst]), 32'd1);
        while (!done_s[inst] && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        err = err_a[inst]; fv = fv_s[inst]; fvec = fvec_a[inst];
        pass = pass_s[inst]; sig = sig_a[inst];
        check("busy_in_done", 32'(busy_s[inst]), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'({done_s[inst], busy_s[inst]}), 32'd0);
    endtask

    typedef struct {
        int         inst;
        logic [3:0] sa0;
        logic [3:0] sa1;
        int         exp_err;
        logic       exp_fv;
        logic [2:0] exp_fvec;
        logic       exp_pass;
    } tv_t;

    initial begin
        tv_t tv [7];
        int lat, m_err, busy_cnt, exp_lat;
        logic [7:0] err, sig, m_sig, sig_ok, sig_f;
        logic fv, pass, m_fv, m_pass;
        logic [2:0] fvec, m_fvec;
        logic [3:0] r0, r1;
        int inst;

        tv[0] = '{0, 4'h0, 4'h0, 0,  1'b0, 3'd0, 1'b1};
        tv[1] = '{0, 4'h1, 4'h0, 1,  1'b1, 3'd7, 1'b0};
        tv[2] = '{1, 4'h0, 4'h2, 8,  1'b1, 3'd1, 1'b0};
        tv[3] = '{0, 4'h4, 4'h0, 6,  1'b1, 3'd1, 1'b0};
        tv[4] = '{0, 4'h0, 4'h8, 6,  1'b1, 3'd0, 1'b0};
        tv[5] = '{2, 4'h0, 4'h2, 7,  1'b1, 3'd1, 1'b0};
        tv[6] = '{1, 4'h0, 4'h0, 0,  1'b0, 3'd0, 1'b1};

        rst_n = 1'b0; start_s = 3'b000; abort_s = 1'b0; sa0_s = 4'h0; sa1_s = 4'h0;
        sig_ok = 8'h00; sig_f = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_outputs", 32'({busy_s[0], done_s[0], pass_s[0], fv_s[0], err0_s, fvec_a[0], sig_a[0], in_s[0]}), 32'd0);

        // Directed fault table.
        for (int i = 0; i < 7; i++) begin
            do_run(tv[i].inst, tv[i].sa0, tv[i].sa1, lat, err, fv, fvec, pass, sig);
            model(tv[i].inst, tv[i].sa0, tv[i].sa1, m_err, m_fv, m_fvec, m_pass, m_sig);
            exp_lat = 8 * passes_p[tv[i].inst] * (settle_p[tv[i].inst] + 2) + 1;
            check("tbl_latency", 32'(lat), 32'(exp_lat));
            check("tbl_err_cnt", 32'(err), 32'(tv[i].exp_err));
            check("tbl_fail_valid", 32'(fv), 32'(tv[i].exp_fv));
            check("tbl_fail_vec", 32'(fvec), 32'(tv[i].exp_fvec));
            check("tbl_pass", 32'(pass), 32'(tv[i].exp_pass));
            check("tbl_sig", 32'(sig), 32'(m_sig));
            if (i == 0) sig_ok = sig;
            if (i == 3) sig_f = sig;
            repeat (2) @(negedge clk);
        end
`ifdef SIG_MISR_EN
        check("misr_fault_visible", 32'(sig_ok != sig_f), 32'd1);
`endif

        // Random fault patterns against the reference model.
        for (int i = 0; i < 12; i++) begin
            inst = $urandom_range(0, 2);
            r0 = 4'($urandom_range(0, 15));
            r1 = 4'($urandom_range(0, 15)) & ~r0;
            do_run(inst, r0, r1, lat, err, fv, fvec, pass, sig);
            model(inst, r0, r1, m_err, m_fv, m_fvec, m_pass, m_sig);
            check("rnd_err_cnt", 32'(err), 32'(m_err));
            check("rnd_fail_valid", 32'(fv), 32'(m_fv));
            check("rnd_fail_vec", 32'(fvec), 32'(m_fv ? m_fvec : 3'd0));
            check("rnd_pass", 32'(pass), 32'(m_pass));
            check("rnd_sig", 32'(sig), 32'(m_sig));
            @(negedge clk);
        end

        // Abort during APPLY of vector 4.
        sa0_s = 4'h0; sa1_s = 4'h0;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (16) @(negedge clk);
        check("abort_pre_vec", 32'(in_s[0]), 32'd4);
        abort_s = 1'b1;
        @(negedge clk);
        abort_s = 1'b0;
        check("abort_idle", 32'({busy_s[0], in_s[0]}), 32'd0);
        busy_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            busy_cnt += int'(done_s[0]) + int'(busy_s[0]);
        end
        check("abort_no_done", 32'(busy_cnt), 32'd0);
        check("abort_pass_low", 32'(pass_s[0]), 32'd0);
        do_run(0, 4'h0, 4'h0, lat, err, fv, fvec, pass, sig);
        check("restart_latency", 32'(lat), 32'd33);
        check("restart_pass", 32'({pass, fv, err}), 32'h200);

        // Start held high across a complete run: exactly one run.
        start_s[0] = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!done_s[0] && lat < 400);
        check("held_latency", 32'(lat), 32'd33);
        busy_cnt = 0;
        repeat (30) begin @(negedge clk); busy_cnt += int'(busy_s[0]); end
        check("held_no_rerun", 32'(busy_cnt), 32'd0);
        start_s[0] = 1'b0;
        @(negedge clk);

        // Async reset while in COMPARE, start held throughout.
        start_s[0] = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_run", 32'({busy_s[0], done_s[0], pass_s[0], fv_s[0], err0_s, fvec_a[0], sig_a[0], in_s[0]}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        busy_cnt = 0;
        repeat (40) begin @(negedge clk); busy_cnt += int'(busy_s[0]); end
        check("rst_no_rerun", 32'(busy_cnt), 32'd0);
        start_s[0] = 1'b0;
        @(negedge clk);
        do_run(0, 4'h0, 4'h0, lat, err, fv, fvec, pass, sig);
        check("post_rst_run", 32'({lat[7:0], pass, err}), 32'({8'd33, 1'b1, 8'd0}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
